// File: rtl/qpsk_pkg.sv
// Shared constants, state type and helper functions for the QPSK transmit modulator.
package qpsk_pkg;

  localparam int SYMS_PER_WORD = 16;
  localparam int DIBIT_W       = 2;
  localparam int WORD_W        = SYMS_PER_WORD * DIBIT_W;

  // Differential phase increments in quarter turns, indexed by dibit value.
  localparam logic [1:0] PH_INC_00 = 2'd0;
  localparam logic [1:0] PH_INC_01 = 2'd1;
  localparam logic [1:0] PH_INC_11 = 2'd2;
  localparam logic [1:0] PH_INC_10 = 2'd3;

  // Phase-to-sign table: bit 1 set means I is negative, bit 0 set means Q is negative.
  localparam logic [1:0] PH_SIGN_0 = 2'b00;
  localparam logic [1:0] PH_SIGN_1 = 2'b10;
  localparam logic [1:0] PH_SIGN_2 = 2'b11;
  localparam logic [1:0] PH_SIGN_3 = 2'b01;

  // Settings-bus register addresses used by the wrapping noc_block.
  localparam logic [7:0] SR_QPSK_TX_AMPLITUDE = 8'd192;
  localparam logic [7:0] SR_QPSK_TX_DIFF_EN   = 8'd193;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } qpsk_state_t;

  function automatic logic [1:0] phase_inc(input logic [DIBIT_W-1:0] d);
    case (d)
      2'b00:   phase_inc = PH_INC_00;
      2'b01:   phase_inc = PH_INC_01;
      2'b11:   phase_inc = PH_INC_11;
      default: phase_inc = PH_INC_10;
    endcase
  endfunction

  function automatic logic [1:0] phase_sign(input logic [1:0] p);
    case (p)
      2'd0:    phase_sign = PH_SIGN_0;
      2'd1:    phase_sign = PH_SIGN_1;
      2'd2:    phase_sign = PH_SIGN_2;
      default: phase_sign = PH_SIGN_3;
    endcase
  endfunction

endpackage

// File: rtl/qpsk_symbol_mapper.sv
// Combinational dibit-to-constellation mapper with optional differential encoding.
// In plain mode the dibit bits directly select the I/Q signs and the phase passes through.
module qpsk_symbol_mapper
  import qpsk_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [DIBIT_W-1:0] dibit,
  input  logic [1:0]         phase,
  input  logic               diff_en,
  input  logic [WIDTH-1:0]   amp,
  output logic [WIDTH-1:0]   i_comp,
  output logic [WIDTH-1:0]   q_comp,
  output logic [1:0]         next_phase
);

  logic [WIDTH-1:0] neg_amp;
  logic [1:0]       sign;

  assign neg_amp = ~amp + WIDTH'(1);

  // Pick the sign pattern from either the raw dibit or the advanced differential phase.
  always_comb begin
    next_phase = phase;
    sign       = dibit;
    if (diff_en) begin
      next_phase = phase + phase_inc(dibit);
      sign       = phase_sign(next_phase);
    end
    i_comp = sign[1] ? neg_amp : amp;
    q_comp = sign[0] ? neg_amp : amp;
  end

endmodule

// File: rtl/qpsk_mod_axis.sv
// QPSK transmit modulator: unpacks 16 dibits per AXI-stream word, maps each to a
// constellation point and holds it for SPS output samples. The output register
// always carries the current sample; counters index the sample within the word.
module qpsk_mod_axis
  import qpsk_pkg::*;
#(
  parameter int SPS   = 16,
  parameter int WIDTH = 16
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst,
  input  logic                 clear,
  input  logic                 diff_en,
  input  logic [WIDTH-1:0]     amplitude,
  input  logic [WORD_W-1:0]    i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [2*WIDTH-1:0]   o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic                 busy
);

  localparam int SMP_W = (SPS > 2) ? $clog2(SPS) : 1;
  localparam int SYM_W = $clog2(SYMS_PER_WORD);

  qpsk_state_t       state;
  logic [WORD_W-1:0] shift_reg;
  logic              tlast_reg;
  logic              diff_reg;
  logic [WIDTH-1:0]  amp_reg;
  logic [1:0]        phase;
  logic [SYM_W-1:0]  sym_cnt;
  logic [SMP_W-1:0]  smp_cnt;

  logic              last_smp;
  logic              last_sym;
  logic              load;
  logic [WIDTH-1:0]  amp_sat;
  logic [DIBIT_W-1:0] map_dibit;
  logic              map_diff;
  logic [WIDTH-1:0]  map_amp;
  logic [WIDTH-1:0]  map_i;
  logic [WIDTH-1:0]  map_q;
  logic [1:0]        map_phase;

  assign o_tvalid = (state == ST_ACTIVE);
  assign busy     = o_tvalid;
  assign last_smp = (smp_cnt == SMP_W'(SPS - 1));
  assign last_sym = (sym_cnt == SYM_W'(SYMS_PER_WORD - 1));
  assign i_tready = !o_tvalid || (o_tready && last_smp && last_sym);
  assign load     = i_tvalid && i_tready;

  // A negative amplitude request clamps to full-scale positive so -A stays representable.
  assign amp_sat = amplitude[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : amplitude;

  // On a load the mapper sees the fresh word and settings; otherwise the latched ones.
  assign map_dibit = load ? i_tdata[WORD_W-1 -: DIBIT_W] : shift_reg[WORD_W-1 -: DIBIT_W];
  assign map_diff  = load ? diff_en : diff_reg;
  assign map_amp   = load ? amp_sat : amp_reg;

  qpsk_symbol_mapper #(.WIDTH(WIDTH)) u_mapper (
    .dibit      (map_dibit),
    .phase      (phase),
    .diff_en    (map_diff),
    .amp        (map_amp),
    .i_comp     (map_i),
    .q_comp     (map_q),
    .next_phase (map_phase)
  );

  // Handshake FSM, sample/symbol counters and registered output sample.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      tlast_reg <= 1'b0;
      diff_reg  <= 1'b0;
      amp_reg   <= '0;
      phase     <= '0;
      sym_cnt   <= '0;
      smp_cnt   <= '0;
      o_tdata   <= '0;
      o_tlast   <= 1'b0;
    end else if (clear) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      tlast_reg <= 1'b0;
      diff_reg  <= 1'b0;
      amp_reg   <= '0;
      phase     <= '0;
      sym_cnt   <= '0;
      smp_cnt   <= '0;
      o_tdata   <= '0;
      o_tlast   <= 1'b0;
    end else if (load) begin
      state     <= ST_ACTIVE;
      shift_reg <= {i_tdata[WORD_W-DIBIT_W-1:0], {DIBIT_W{1'b0}}};
      tlast_reg <= i_tlast;
      diff_reg  <= diff_en;
      amp_reg   <= amp_sat;
      phase     <= map_phase;
      sym_cnt   <= '0;
      smp_cnt   <= '0;
      o_tdata   <= {map_i, map_q};
      o_tlast   <= 1'b0;
    end else if (state == ST_ACTIVE && o_tready) begin
      if (last_smp) begin
        if (last_sym) begin
          state   <= ST_IDLE;
          o_tlast <= 1'b0;
        end else begin
          shift_reg <= {shift_reg[WORD_W-DIBIT_W-1:0], {DIBIT_W{1'b0}}};
          phase     <= map_phase;
          sym_cnt   <= sym_cnt + SYM_W'(1);
          smp_cnt   <= '0;
          o_tdata   <= {map_i, map_q};
          o_tlast   <= 1'b0;
        end
      end else begin
        smp_cnt <= smp_cnt + SMP_W'(1);
        o_tlast <= tlast_reg && last_sym && (smp_cnt == SMP_W'(SPS - 2));
      end
    end
  end

endmodule

// File: tb/tb_qpsk_mod_axis.sv
// Directed self-checking bench for qpsk_mod_axis with SPS=16, WIDTH=16.
module tb_qpsk_mod_axis;

  logic        ce_clk = 1'b0;
  logic        ce_rst;
  logic        clear;
  logic        diff_en;
  logic [15:0] amplitude;
  logic [31:0] i_tdata;
  logic        i_tlast;
  logic        i_tvalid;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] words    [2];
  logic        lasts    [2];
  logic [31:0] exp_syms [2][16];

  qpsk_mod_axis #(.SPS(16), .WIDTH(16)) dut (
    .ce_clk    (ce_clk),
    .ce_rst    (ce_rst),
    .clear     (clear),
    .diff_en   (diff_en),
    .amplitude (amplitude),
    .i_tdata   (i_tdata),
    .i_tlast   (i_tlast),
    .i_tvalid  (i_tvalid),
    .i_tready  (i_tready),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .busy      (busy)
  );

  // Free-running 100 MHz block clock.
  always #5 ce_clk = ~ce_clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic fillSyms(input int w, input logic [31:0] s0, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [31:0] s3, input bit repeat4,
                          input logic [31:0] rest);
    for (int k = 0; k < 16; k++) begin
      if (repeat4 || k < 4) begin
        case (k % 4)
          0:       exp_syms[w][k] = s0;
          1:       exp_syms[w][k] = s1;
          2:       exp_syms[w][k] = s2;
          default: exp_syms[w][k] = s3;
        endcase
      end else begin
        exp_syms[w][k] = rest;
      end
    end
  endtask

  // Offers nwords words and checks every transferred sample until stop_at samples have moved.
  task automatic applyStimulus(input int nwords, input bit rand_ready, input int stop_at,
                               input bit check_b2b, input string tag);
    int sample_idx = 0;
    int wi = 0;
    int cycles = 0;
    int ready_hi = 0;
    int valid_cycles = 0;
    int bubbles = 0;
    int max_cycles = stop_at * 4 + 64;
    int w;
    int s;
    bit accepted_prev = 1'b0;
    bit prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic exp_last;
    while (sample_idx < stop_at && cycles < max_cycles) begin
      o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_tvalid = (wi < nwords);
      i_tdata  = words[(wi < nwords) ? wi : 0];
      i_tlast  = lasts[(wi < nwords) ? wi : 0];
      #1;
      if (accepted_prev) checkOutput({tag, "_latency"}, 32'(o_tvalid), 32'd1);
      if (prev_stall) checkOutput({tag, "_stable"}, o_tdata, prev_data);
      if (o_tvalid) valid_cycles++;
      else if (sample_idx > 0) bubbles++;
      if (i_tready && sample_idx < nwords * 256 - 1) ready_hi++;
      accepted_prev = 1'b0;
      if (i_tvalid && i_tready) begin
        if (wi == 0) begin
          checkOutput({tag, "_idle_at_accept"}, 32'(o_tvalid), 32'd0);
          accepted_prev = 1'b1;
        end else begin
          checkOutput({tag, "_accept_at"}, 32'(sample_idx), 32'(wi * 256 - 1));
        end
        wi++;
      end
      if (o_tvalid && o_tready) begin
        w = sample_idx / 256;
        s = (sample_idx % 256) / 16;
        exp_last = lasts[w] && ((sample_idx % 256) == 255);
        checkOutput($sformatf("%s_data[%0d]", tag, sample_idx), o_tdata, exp_syms[w][s]);
        checkOutput($sformatf("%s_last[%0d]", tag, sample_idx), 32'(o_tlast), 32'(exp_last));
        sample_idx++;
      end
      prev_stall = o_tvalid && !o_tready;
      prev_data  = o_tdata;
      @(posedge ce_clk);
      #1;
      cycles++;
    end
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    checkOutput({tag, "_samples"}, 32'(sample_idx), 32'(stop_at));
    checkOutput({tag, "_bubbles"}, 32'(bubbles), 32'd0);
    if (check_b2b) begin
      checkOutput({tag, "_valid_cycles"}, 32'(valid_cycles), 32'd512);
      checkOutput({tag, "_ready_cycles"}, 32'(ready_hi), 32'd2);
    end
  endtask

  initial begin
    ce_rst    = 1'b1;
    clear     = 1'b0;
    diff_en   = 1'b0;
    amplitude = 16'h4000;
    i_tdata   = '0;
    i_tlast   = 1'b0;
    i_tvalid  = 1'b0;
    o_tready  = 1'b1;
    repeat (3) @(posedge ce_clk);
    #1;
    checkOutput("rst_tvalid", 32'(o_tvalid), 32'd0);
    checkOutput("rst_tlast", 32'(o_tlast), 32'd0);
    checkOutput("rst_tdata", o_tdata, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_tready", 32'(i_tready), 32'd1);
    ce_rst = 1'b0;
    @(posedge ce_clk);
    #1;

    $display("[TB] plain QPSK single word");
    words[0] = 32'h1B000000;
    lasts[0] = 1'b1;
    fillSyms(0, 32'h40004000, 32'h4000C000, 32'hC0004000, 32'hC000C000, 1'b0, 32'h40004000);
    applyStimulus(1, 1'b0, 256, 1'b0, "nd");
    checkOutput("nd_idle_after", 32'(o_tvalid), 32'd0);

    $display("[TB] differential QPSK");
    diff_en  = 1'b1;
    words[0] = 32'h55555555;
    lasts[0] = 1'b0;
    fillSyms(0, 32'hC0004000, 32'hC000C000, 32'h4000C000, 32'h40004000, 1'b1, 32'h0);
    applyStimulus(1, 1'b0, 256, 1'b0, "diff");

    $display("[TB] back-to-back words");
    diff_en  = 1'b0;
    words[0] = 32'h1B000000;
    lasts[0] = 1'b0;
    words[1] = 32'hE4000000;
    lasts[1] = 1'b1;
    fillSyms(0, 32'h40004000, 32'h4000C000, 32'hC0004000, 32'hC000C000, 1'b0, 32'h40004000);
    fillSyms(1, 32'hC000C000, 32'hC0004000, 32'h4000C000, 32'h40004000, 1'b0, 32'h40004000);
    applyStimulus(2, 1'b0, 512, 1'b1, "b2b");
    checkOutput("b2b_idle_after", 32'(o_tvalid), 32'd0);

    $display("[TB] random backpressure");
    words[0] = 32'h1B000000;
    lasts[0] = 1'b1;
    fillSyms(0, 32'h40004000, 32'h4000C000, 32'hC0004000, 32'hC000C000, 1'b0, 32'h40004000);
    applyStimulus(1, 1'b1, 256, 1'b0, "bp");

    $display("[TB] reset mid-word");
    diff_en  = 1'b1;
    words[0] = 32'h55555555;
    lasts[0] = 1'b1;
    fillSyms(0, 32'hC0004000, 32'hC000C000, 32'h4000C000, 32'h40004000, 1'b1, 32'h0);
    applyStimulus(1, 1'b0, 101, 1'b0, "rst_pre");
    ce_rst = 1'b1;
    #1;
    checkOutput("rst_async_tvalid", 32'(o_tvalid), 32'd0);
    checkOutput("rst_async_tdata", o_tdata, 32'd0);
    checkOutput("rst_async_busy", 32'(busy), 32'd0);
    @(posedge ce_clk);
    #1;
    ce_rst = 1'b0;
    @(posedge ce_clk);
    #1;
    words[0] = 32'h40000000;
    lasts[0] = 1'b0;
    fillSyms(0, 32'hC0004000, 32'hC0004000, 32'hC0004000, 32'hC0004000, 1'b1, 32'h0);
    applyStimulus(1, 1'b0, 16, 1'b0, "rst_post");

    $display("[TB] clear mid-word");
    clear = 1'b1;
    @(posedge ce_clk);
    #1;
    clear = 1'b0;
    checkOutput("clr_tvalid", 32'(o_tvalid), 32'd0);
    checkOutput("clr_tdata", o_tdata, 32'd0);
    checkOutput("clr_tlast", 32'(o_tlast), 32'd0);
    applyStimulus(1, 1'b0, 16, 1'b0, "clr_post");
    clear = 1'b1;
    @(posedge ce_clk);
    #1;
    clear = 1'b0;

    $display("[TB] amplitude saturation");
    diff_en   = 1'b0;
    amplitude = 16'h8000;
    words[0]  = 32'h30000000;
    lasts[0]  = 1'b1;
    fillSyms(0, 32'h7FFF7FFF, 32'h80018001, 32'h7FFF7FFF, 32'h7FFF7FFF, 1'b0, 32'h7FFF7FFF);
    applyStimulus(1, 1'b0, 256, 1'b0, "sat");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
